// File: rtl/lfsr_rng_stream.sv
// -----------------------------------------------------------------------------
// lfsr_rng_stream
//   Fibonacci LFSR random-word generator with a valid/ready output stream.
//   OUT_W freshly generated feedback bits are assembled into one word (first
//   generated bit lands in the MSB) and presented on rnd/rnd_valid.
//   Supports run-time reseeding, enable/pause and all-zero lock-up recovery.
//
//   Optional feature macro: LFSR_BOUND_EN
//     defined   : completed words >= MAX_VAL are discarded and a new word is
//                 built, so every presented word is < MAX_VAL.
//     undefined : every completed word is presented, MAX_VAL is ignored.
//
// Ports
//   clk        in   1      clock, posedge
//   rst        in   1      asynchronous active-high reset
//   en         in   1      1 = generate, 0 = pause (state and count hold)
//   seed_load  in   1      strobe: load seed, abort current word
//   seed       in   WIDTH  seed value (zero selects DEFAULT_SEED)
//   rnd_ready  in   1      consumer accepts rnd this cycle
//   rnd_valid  out  1      rnd holds a complete word
//   rnd        out  OUT_W  random word, stable while rnd_valid=1
//   lockup     out  1      one-cycle pulse on all-zero state recovery
// -----------------------------------------------------------------------------
module lfsr_rng_stream #(
   parameter int unsigned      WIDTH        = 6,
   parameter logic [WIDTH-1:0] TAPS         = 6'h30,
   parameter int unsigned      OUT_W        = 6,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 6'h01,
   parameter int unsigned      MAX_VAL      = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   input  logic             rnd_ready,
   output logic             rnd_valid,
   output logic [OUT_W-1:0] rnd,
   output logic             lockup
);

`ifdef LFSR_BOUND_EN
   localparam bit BOUND_EN = 1'b1;
`else
   localparam bit BOUND_EN = 1'b0;
`endif

   localparam int unsigned CW   = $clog2(OUT_W + 1);
   localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_VALID} fsm_t;

   fsm_t             fsm, fsm_nx;
   logic [WIDTH-1:0] lfsr, lfsr_nx;
   logic [WIDTH-1:0] seed_q, seed_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [OUT_W-1:0] word_sr, word_nx;
   logic [OUT_W-1:0] rnd_nx;
   logic             lockup_nx;

   logic             fb;
   logic [OUT_W-1:0] word_shift;
   logic [WIDTH-1:0] load_val;
   logic             reject;

   always_comb begin
      fb         = ^(lfsr & TAPS);
      // Truncating cast keeps this valid for OUT_W == 1.
      word_shift = OUT_W'({word_sr, fb});
      load_val   = (seed == '0) ? DEFAULT_SEED : seed;
      reject     = BOUND_EN && (32'(word_shift) >= MAX_VAL);
   end

   // The valid flag is simply "the FSM is holding a finished word".
   assign rnd_valid = (fsm == S_VALID);

   always_comb begin
      fsm_nx    = fsm;
      lfsr_nx   = lfsr;
      seed_nx   = seed_q;
      cnt_nx    = cnt;
      word_nx   = word_sr;
      rnd_nx    = rnd;
      lockup_nx = 1'b0;

      if (seed_load) begin
         seed_nx = load_val;
         lfsr_nx = load_val;
         cnt_nx  = '0;
         fsm_nx  = S_IDLE;
      end else begin
         unique case (fsm)
            S_IDLE: begin
               if (en) fsm_nx = S_FILL;
            end
            S_FILL: begin
               if (en) begin
                  if (lfsr == '0) begin
                     // Stuck register: restore the last seed instead of shifting.
                     lfsr_nx   = seed_q;
                     lockup_nx = 1'b1;
                  end else begin
                     lfsr_nx = {lfsr[WIDTH-2:0], fb};
                     word_nx = word_shift;
                     if (cnt == LAST) begin
                        cnt_nx = '0;
                        if (!reject) begin
                           rnd_nx = word_shift;
                           fsm_nx = S_VALID;
                        end
                     end else begin
                        cnt_nx = cnt + 1'b1;
                     end
                  end
               end
            end
            S_VALID: begin
               if (rnd_ready) fsm_nx = en ? S_FILL : S_IDLE;
            end
            default: fsm_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm    <= S_IDLE;
         lfsr   <= DEFAULT_SEED;
         seed_q <= DEFAULT_SEED;
         cnt    <= '0;
         rnd    <= '0;
         lockup <= 1'b0;
      end else begin
         fsm    <= fsm_nx;
         lfsr   <= lfsr_nx;
         seed_q <= seed_nx;
         cnt    <= cnt_nx;
         rnd    <= rnd_nx;
         lockup <= lockup_nx;
      end
   end

   // Assembly register is always overwritten before use, so it needs no reset.
   always_ff @(posedge clk) begin
      word_sr <= word_nx;
   end

endmodule
